// File: rtl/demux_1x4_stream.sv
// demux_1x4_stream: 1-to-4 valid/ready stream demux with one registered output slot per port.
// Optional per-port handshake counters are enabled by defining DEMUX_STATS_EN.
module demux_1x4_stream #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             S1,
    input  logic             S0,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic             A_valid,
    output logic             B_valid,
    output logic             C_valid,
    output logic             D_valid,
    input  logic             A_ready,
    input  logic             B_ready,
    input  logic             C_ready,
    input  logic             D_ready
`ifdef DEMUX_STATS_EN
    ,
    output logic [7:0]       CNT_A,
    output logic [7:0]       CNT_B,
    output logic [7:0]       CNT_C,
    output logic [7:0]       CNT_D
`endif
);
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]       r_state [4];
    logic [WIDTH-1:0] r_data  [4];
    logic [1:0]       w_sel;
    logic [3:0]       w_rdy;
    logic [3:0]       w_valid;
    logic [3:0]       w_load;

    // Port index: A=0, B=1, C=2, D=3, so S0 is the high bit of the index.
    assign w_sel = {S0, S1};
    assign w_rdy = {D_ready, C_ready, B_ready, A_ready};

    // Decode per-port occupancy from the FSM state.
    always_comb begin
        w_valid = '0;
        for (int i = 0; i < 4; i++) w_valid[i] = (r_state[i] == FULL);
    end

    // Accept when the selected slot is empty or is draining this cycle.
    assign din_ready = !w_valid[w_sel] || w_rdy[w_sel];

    // One-hot load strobe for the slot receiving the current transfer.
    always_comb begin
        w_load = '0;
        w_load[w_sel] = din_valid && din_ready;
    end

    // Slot FSMs: a load wins over a drain, giving one word per cycle pass-through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_state[i] <= EMPTY;
                r_data[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_load[i]) begin
                    r_state[i] <= FULL;
                    r_data[i]  <= din;
                end else if (w_rdy[i]) begin
                    r_state[i] <= EMPTY;
                end
            end
        end
    end

    assign A = r_data[0];
    assign B = r_data[1];
    assign C = r_data[2];
    assign D = r_data[3];
    assign A_valid = w_valid[0];
    assign B_valid = w_valid[1];
    assign C_valid = w_valid[2];
    assign D_valid = w_valid[3];

`ifdef DEMUX_STATS_EN
    logic [7:0] r_cnt [4];

    // Saturating count of completed output handshakes per port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (w_valid[i] && w_rdy[i] && r_cnt[i] != 8'hFF) r_cnt[i] <= r_cnt[i] + 8'd1;
        end
    end

    assign CNT_A = r_cnt[0];
    assign CNT_B = r_cnt[1];
    assign CNT_C = r_cnt[2];
    assign CNT_D = r_cnt[3];
`endif
endmodule

// File: tb/tb_demux_1x4_stream.sv
// tb_demux_1x4_stream: directed self-checking bench for demux_1x4_stream.
module tb_demux_1x4_stream;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] din = '0;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic       S1 = 1'b0, S0 = 1'b0;
    logic [3:0] A, B, C, D;
    logic       A_valid, B_valid, C_valid, D_valid;
    logic       A_ready = 1'b1, B_ready = 1'b1, C_ready = 1'b1, D_ready = 1'b1;
    int         checks = 0;
    int         failures = 0;
`ifdef DEMUX_STATS_EN
    logic [7:0] CNT_A, CNT_B, CNT_C, CNT_D;
`endif

    demux_1x4_stream #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .S1(S1), .S0(S0), .A(A), .B(B), .C(C), .D(D),
        .A_valid(A_valid), .B_valid(B_valid), .C_valid(C_valid), .D_valid(D_valid),
        .A_ready(A_ready), .B_ready(B_ready), .C_ready(C_ready), .D_ready(D_ready)
`ifdef DEMUX_STATS_EN
        , .CNT_A(CNT_A), .CNT_B(CNT_B), .CNT_C(CNT_C), .CNT_D(CNT_D)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s1, input logic s0, input logic [3:0] d);
        din_valid = v;
        S1 = s1;
        S0 = s0;
        din = d;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, 4'hF);
        #1;
        checks++;
        if ({A_valid, B_valid, C_valid, D_valid} !== 4'b0000 || {A, B, C, D} !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs: valids=%b data=%h expected 0000/0000", {A_valid, B_valid, C_valid, D_valid}, {A, B, C, D});
        end
        checks++;
        if (din_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_din_ready: got %b expected 1", din_ready);
        end
        tick();
        checks++;
        if (A_valid !== 1'b0 || A !== 4'h0) begin
            failures++;
            $display("FAIL reset_no_transfer: A_valid=%b A=%h expected 0/0", A_valid, A);
        end
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_routing();
        logic [3:0] val [4];
        logic [1:0] sel [4];
        val[0] = 4'h5; val[1] = 4'h6; val[2] = 4'h7; val[3] = 4'h8;
        sel[0] = 2'b00; sel[1] = 2'b10; sel[2] = 2'b01; sel[3] = 2'b11;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, sel[k][1], sel[k][0], val[k]);
            tick();
            checks++;
            case (k)
                0: if (!(A_valid === 1'b1 && A === 4'h5 && {B_valid, C_valid, D_valid} === 3'b000)) begin
                    failures++;
                    $display("FAIL route_A: A=%h valids=%b expected A=5 valids=1000", A, {A_valid, B_valid, C_valid, D_valid});
                end
                1: if (!(B_valid === 1'b1 && B === 4'h6 && {A_valid, C_valid, D_valid} === 3'b000)) begin
                    failures++;
                    $display("FAIL route_B: B=%h valids=%b expected B=6 valids=0100", B, {A_valid, B_valid, C_valid, D_valid});
                end
                2: if (!(C_valid === 1'b1 && C === 4'h7 && {A_valid, B_valid, D_valid} === 3'b000)) begin
                    failures++;
                    $display("FAIL route_C: C=%h valids=%b expected C=7 valids=0010", C, {A_valid, B_valid, C_valid, D_valid});
                end
                default: if (!(D_valid === 1'b1 && D === 4'h8 && {A_valid, B_valid, C_valid} === 3'b000)) begin
                    failures++;
                    $display("FAIL route_D: D=%h valids=%b expected D=8 valids=0001", D, {A_valid, B_valid, C_valid, D_valid});
                end
            endcase
        end
        drive(1'b0, 1'b1, 1'b0, 4'hE);
        A_ready = 1'b0;
        tick();
        checks++;
        if ({A_valid, B_valid, C_valid, D_valid} !== 4'b0000 || {A, B, C, D} !== 16'h5678) begin
            failures++;
            $display("FAIL idle_ignored: valids=%b data=%h expected 0000/5678", {A_valid, B_valid, C_valid, D_valid}, {A, B, C, D});
        end
        A_ready = 1'b1;
    endtask

    task automatic test_backpressure();
        B_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 4'h3);
        tick();
        drive(1'b1, 1'b1, 1'b0, 4'hC);
        #1;
        checks++;
        if (din_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_ready_low: din_ready=%b expected 0", din_ready);
        end
        tick();
        checks++;
        if (B_valid !== 1'b1 || B !== 4'h3) begin
            failures++;
            $display("FAIL bp_hold: B_valid=%b B=%h expected 1/3", B_valid, B);
        end
        B_ready = 1'b1;
        #1;
        checks++;
        if (din_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready_release: din_ready=%b expected 1", din_ready);
        end
        tick();
        checks++;
        if (B_valid !== 1'b1 || B !== 4'hC) begin
            failures++;
            $display("FAIL bp_second_word: B_valid=%b B=%h expected 1/c", B_valid, B);
        end
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        tick();
        checks++;
        if (B_valid !== 1'b0 || B !== 4'hC) begin
            failures++;
            $display("FAIL bp_drain: B_valid=%b B=%h expected 0/c", B_valid, B);
        end
    endtask

    task automatic test_independence();
        B_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 4'h2);
        tick();
        drive(1'b1, 1'b1, 1'b1, 4'h9);
        #1;
        checks++;
        if (din_ready !== 1'b1) begin
            failures++;
            $display("FAIL indep_ready: din_ready=%b expected 1", din_ready);
        end
        tick();
        checks++;
        if (D_valid !== 1'b1 || D !== 4'h9 || B_valid !== 1'b1 || B !== 4'h2) begin
            failures++;
            $display("FAIL indep_load: D_valid=%b D=%h B_valid=%b B=%h expected 1/9/1/2", D_valid, D, B_valid, B);
        end
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        B_ready = 1'b1;
        tick();
    endtask

    task automatic test_pass_through();
        int bad = 0;
        for (int k = 1; k <= 15; k++) begin
            drive(1'b1, 1'b0, 1'b0, 4'(k));
            #1;
            if (din_ready !== 1'b1) bad++;
            tick();
            if (A_valid !== 1'b1 || A !== 4'(k)) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL pass_through: %0d bad cycles, expected 0", bad);
        end
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        tick();
        checks++;
        if (A_valid !== 1'b0 || A !== 4'hF) begin
            failures++;
            $display("FAIL pass_through_end: A_valid=%b A=%h expected 0/f", A_valid, A);
        end
    endtask

    task automatic test_reset_mid();
        A_ready = 1'b0;
        C_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 4'hA);
        tick();
        drive(1'b1, 1'b0, 1'b1, 4'h5);
        tick();
        drive(1'b0, 1'b0, 1'b1, 4'h0);
        checks++;
        if (A_valid !== 1'b1 || A !== 4'hA || C_valid !== 1'b1 || C !== 4'h5) begin
            failures++;
            $display("FAIL mid_setup: A_valid=%b A=%h C_valid=%b C=%h expected 1/a/1/5", A_valid, A, C_valid, C);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (A_valid !== 1'b0 || C_valid !== 1'b0 || A !== 4'h0 || C !== 4'h0) begin
            failures++;
            $display("FAIL mid_reset_async: A_valid=%b A=%h C_valid=%b C=%h expected all 0", A_valid, A, C_valid, C);
        end
        checks++;
        if (din_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_ready: din_ready=%b expected 1", din_ready);
        end
        #1 rst_n = 1'b1;
        C_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 4'h4);
        tick();
        checks++;
        if (C_valid !== 1'b1 || C !== 4'h4 || A_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_after_release: C_valid=%b C=%h A_valid=%b expected 1/4/0", C_valid, C, A_valid);
        end
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        A_ready = 1'b1;
        tick();
    endtask

`ifdef DEMUX_STATS_EN
    task automatic test_stats();
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 4'h1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        tick();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'b0, 1'b1, 4'(k));
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        tick();
        checks++;
        if (CNT_C !== 8'd10 || CNT_A !== 8'd1) begin
            failures++;
            $display("FAIL stats_count: CNT_C=%0d CNT_A=%0d expected 10/1", CNT_C, CNT_A);
        end
        for (int k = 0; k < 290; k++) begin
            drive(1'b1, 1'b0, 1'b1, 4'(k));
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        tick();
        checks++;
        if (CNT_C !== 8'd255) begin
            failures++;
            $display("FAIL stats_saturate: CNT_C=%0d expected 255", CNT_C);
        end
        checks++;
        if (CNT_A !== 8'd1 || CNT_B !== 8'd0 || CNT_D !== 8'd0) begin
            failures++;
            $display("FAIL stats_others: CNT_A=%0d CNT_B=%0d CNT_D=%0d expected 1/0/0", CNT_A, CNT_B, CNT_D);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_routing();
        test_backpressure();
        test_independence();
        test_pass_through();
        test_reset_mid();
`ifdef DEMUX_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
